pipe_stage4: RTL and testbench

Per-lane patience tracker that sits directly downstream of the interval-compare stage in the 12-lane scoring pipeline. It consumes the per-lane `out_of_mode_interval` flags and keeps a saturating count of consecutive in-interval beats for each lane. A lane is retired (early exit) once its count reaches a programmable patience. The counts are registered and fed back to the compare stage's `interval_cnt_i`. The output has a one-deep valid/ready register.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/lane_patience_cnt.sv | 45 ++++
 rtl/pipe_stage4.sv | 78 +++++++
 tb/tb_pipe_stage4.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the scoring pipeline stages.
// Lane count width and lane count are fixed here so every stage agrees.
package pipe_pkg;

  localparam int PARALLEL_SIZE = 12;
  localparam int PARA          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stage4_state_e;

  typedef logic [PARA-1:0] lane_cnt_t;

  function automatic lane_cnt_t sat_inc(input lane_cnt_t c);
    return (c == '1) ? c : lane_cnt_t'(c + 1'b1);
  endfunction

endpackage

// File: rtl/lane_patience_cnt.sv
// One lane: saturating run length of in-interval beats with a sticky exit flag.
// State moves only when en is high; clr restarts the lane in the same update.
module lane_patience_cnt
  import pipe_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      en,
  input  logic      clr,
  input  logic      oom,
  input  lane_cnt_t patience,
  output lane_cnt_t cnt,
  output logic      exit
);

  lane_cnt_t base_cnt;
  lane_cnt_t cnt_nxt;
  logic      base_exit;
  logic      exit_nxt;

  // A restart must not let stale lane state leak into the restarting beat.
  always_comb begin
    base_cnt  = clr ? '0   : cnt;
    base_exit = clr ? 1'b0 : exit;
    cnt_nxt   = base_cnt;
    exit_nxt  = base_exit;
    if (!base_exit) begin
      cnt_nxt = oom ? '0 : sat_inc(base_cnt);
      if ((patience != '0) && (cnt_nxt >= patience)) begin
        exit_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt  <= '0;
      exit <= 1'b0;
    end else if (en) begin
      cnt  <= cnt_nxt;
      exit <= exit_nxt;
    end
  end

endmodule

// File: rtl/pipe_stage4.sv
// Per-lane patience tracker with early exit; 1-cycle latency to a one-deep output register.
// Back-pressure: ready_o drops while the held beat is not taken, freezing lane state.
module pipe_stage4
  import pipe_pkg::*;
(
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic                                first_i,
  input  logic [PARALLEL_SIZE-1:0]            out_of_mode_interval_i,
  input  logic [PARA-1:0]                     patience_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [PARALLEL_SIZE-1:0]            exit_o,
  output logic                                all_exit_o,
  output logic [PARALLEL_SIZE-1:0][PARA-1:0]  interval_cnt_o
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       valid_q;
  logic       accept;
  logic       emit;
  logic       run_live;
  logic       all_exit;

  assign all_exit = &exit_o;
  assign ready_o  = !valid_q || ready_i;
  assign accept   = valid_i && ready_o;
  // RUN with every lane exited is already finished, even before state_q reaches DONE.
  assign run_live = (state_q == S_RUN) && !all_exit;
  assign emit     = accept && (first_i || run_live);

  always_comb begin
    state_d = state_q;
    if (accept && first_i) begin
      state_d = S_RUN;
    end else if ((state_q == S_RUN) && all_exit) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (emit) begin
        valid_q <= 1'b1;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < PARALLEL_SIZE; i++) begin : g_lane
    lane_patience_cnt u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .en       (emit),
      .clr      (first_i),
      .oom      (out_of_mode_interval_i[i]),
      .patience (patience_i),
      .cnt      (interval_cnt_o[i]),
      .exit     (exit_o[i])
    );
  end

  assign valid_o    = valid_q;
  assign all_exit_o = all_exit;

endmodule

// File: tb/tb_pipe_stage4.sv
// Scoreboard bench for pipe_stage4: a behavioural lane model feeds a queue of expected output beats.
module tb_pipe_stage4;
  import pipe_pkg::*;

  typedef struct packed {
    logic [PARALLEL_SIZE-1:0]           ex;
    logic [PARALLEL_SIZE-1:0][PARA-1:0] cnt;
  } beat_t;

  logic                               clk;
  logic                               rst_ni;
  logic                               valid_i;
  logic                               ready_o;
  logic                               first_i;
  logic [PARALLEL_SIZE-1:0]           out_of_mode_interval_i;
  logic [PARA-1:0]                    patience_i;
  logic                               valid_o;
  logic                               ready_i;
  logic [PARALLEL_SIZE-1:0]           exit_o;
  logic                               all_exit_o;
  logic [PARALLEL_SIZE-1:0][PARA-1:0] interval_cnt_o;

  pipe_stage4 dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .valid_i                (valid_i),
    .ready_o                (ready_o),
    .first_i                (first_i),
    .out_of_mode_interval_i (out_of_mode_interval_i),
    .patience_i             (patience_i),
    .valid_o                (valid_o),
    .ready_i                (ready_i),
    .exit_o                 (exit_o),
    .all_exit_o             (all_exit_o),
    .interval_cnt_o         (interval_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_pop  = 0;

  logic [PARALLEL_SIZE-1:0][PARA-1:0] mcnt;
  logic [PARALLEL_SIZE-1:0]           mexit;
  stage4_state_e                      mstate;
  bit                                 mvalid;
  beat_t                              sb[$];

  // Drive one cycle of inputs, check live state and any popped beat, then advance the model.
  task automatic step(input bit v, input bit f, input logic [PARALLEL_SIZE-1:0] oom,
                      input logic [PARA-1:0] pat, input bit r, input bit rn);
    beat_t exp;
    bit    acc;
    bit    emit;
    valid_i = v; first_i = f; out_of_mode_interval_i = oom;
    patience_i = pat; ready_i = r; rst_ni = rn;
    #1;
    if (rn) begin
      n_chk++;
      if (interval_cnt_o !== mcnt || exit_o !== mexit || all_exit_o !== (&mexit)) begin
        n_fail++;
        $display("FAIL lane_state: cnt=%h exit=%h all=%b required cnt=%h exit=%h all=%b",
                 interval_cnt_o, exit_o, all_exit_o, mcnt, mexit, &mexit);
      end
      n_chk++;
      if (valid_o !== mvalid) begin
        n_fail++;
        $display("FAIL valid_o: got %b required %b", valid_o, mvalid);
      end
      n_chk++;
      if (ready_o !== (!mvalid || r)) begin
        n_fail++;
        $display("FAIL ready_o: got %b required %b", ready_o, (!mvalid || r));
      end
      if (mvalid && r) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: output beat taken with empty scoreboard");
        end else begin
          exp = sb.pop_front();
          n_pop++;
          if (exit_o !== exp.ex || interval_cnt_o !== exp.cnt || all_exit_o !== (&exp.ex)) begin
            n_fail++;
            $display("FAIL out_beat: cnt=%h exit=%h all=%b required cnt=%h exit=%h all=%b",
                     interval_cnt_o, exit_o, all_exit_o, exp.cnt, exp.ex, &exp.ex);
          end
        end
      end
      acc  = v && (!mvalid || r);
      emit = 1'b0;
      if (acc) begin
        if (f) begin
          mcnt   = '0;
          mexit  = '0;
          mstate = RUN;
          emit   = 1'b1;
        end else begin
          emit = (mstate == RUN);
        end
        if (emit) begin
          for (int i = 0; i < PARALLEL_SIZE; i++) begin
            if (!mexit[i]) begin
              if (oom[i]) mcnt[i] = '0;
              else if (mcnt[i] != 16'hFFFF) mcnt[i] = mcnt[i] + 16'd1;
              if (pat != 0 && mcnt[i] >= pat) mexit[i] = 1'b1;
            end
          end
          if (&mexit) mstate = DONE;
          exp.ex  = mexit;
          exp.cnt = mcnt;
          sb.push_back(exp);
          n_push++;
        end
      end
      if (emit) mvalid = 1'b1;
      else if (r) mvalid = 1'b0;
    end else begin
      mcnt   = '0;
      mexit  = '0;
      mstate = IDLE;
      mvalid = 1'b0;
      sb.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 1, 0);
    n_chk++;
    if (valid_o !== 1'b0 || exit_o !== '0 || all_exit_o !== 1'b0 || interval_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b exit=%h all=%b cnt=%h required all zero",
               valid_o, exit_o, all_exit_o, interval_cnt_o);
    end
  endtask

  task automatic test_start_and_exit();
    logic [PARALLEL_SIZE-1:0][PARA-1:0] ones;
    logic [PARALLEL_SIZE-1:0][PARA-1:0] threes;
    for (int i = 0; i < PARALLEL_SIZE; i++) begin
      ones[i] = 16'd1;
      threes[i] = 16'd3;
    end
    step(1, 1, '0, 16'd3, 1, 1);
    n_chk++;
    if (valid_o !== 1'b1 || interval_cnt_o !== ones || exit_o !== '0) begin
      n_fail++;
      $display("FAIL seq_start: valid=%b cnt=%h exit=%h required 1, all 1, 0", valid_o, interval_cnt_o, exit_o);
    end
    step(1, 0, '0, 16'd3, 1, 1);
    step(1, 0, '0, 16'd3, 1, 1);
    n_chk++;
    if (interval_cnt_o !== threes || exit_o !== 12'hFFF || all_exit_o !== 1'b1 || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lane_exit: cnt=%h exit=%h all=%b valid=%b required all 3, fff, 1, 1",
               interval_cnt_o, exit_o, all_exit_o, valid_o);
    end
    step(1, 0, '0, 16'd3, 1, 1);
    n_chk++;
    if (valid_o !== 1'b0 || interval_cnt_o !== threes) begin
      n_fail++;
      $display("FAIL done_drop: valid=%b cnt=%h required 0 and all 3", valid_o, interval_cnt_o);
    end
  endtask

  task automatic test_lane_reset();
    step(1, 1, '0, 16'd3, 1, 1);
    step(1, 0, '0, 16'd3, 1, 1);
    step(1, 0, 12'h020, 16'd3, 1, 1);
    n_chk++;
    if (interval_cnt_o[5] !== 16'd0 || exit_o !== 12'hFDF || all_exit_o !== 1'b0 || interval_cnt_o[4] !== 16'd3) begin
      n_fail++;
      $display("FAIL lane5_oom: cnt5=%0d cnt4=%0d exit=%h all=%b required 0, 3, fdf, 0",
               interval_cnt_o[5], interval_cnt_o[4], exit_o, all_exit_o);
    end
    // Exited lanes ignore their flags while lane 5 catches up.
    for (int k = 0; k < 3; k++) step(1, 0, 12'hFDF, 16'd3, 1, 1);
    n_chk++;
    if (exit_o !== 12'hFFF || all_exit_o !== 1'b1 || interval_cnt_o[5] !== 16'd3 || interval_cnt_o[0] !== 16'd3) begin
      n_fail++;
      $display("FAIL lane5_catchup: exit=%h all=%b cnt5=%0d cnt0=%0d required fff, 1, 3, 3",
               exit_o, all_exit_o, interval_cnt_o[5], interval_cnt_o[0]);
    end
  endtask

  task automatic test_saturation();
    step(1, 1, '0, 16'd0, 1, 1);
    for (int k = 0; k < 65539; k++) step(1, 0, '0, 16'd0, 1, 1);
    for (int i = 0; i < PARALLEL_SIZE; i++) begin
      n_chk++;
      if (interval_cnt_o[i] !== 16'hFFFF || exit_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL saturation lane %0d: cnt=%h exit=%b required ffff, 0", i, interval_cnt_o[i], exit_o[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [PARALLEL_SIZE-1:0][PARA-1:0] snap;
    logic [PARALLEL_SIZE-1:0]           rnd;
    int push0;
    int pop0;
    step(1, 1, '0, 16'd0, 1, 1);
    snap = interval_cnt_o;
    for (int k = 0; k < 4; k++) begin
      rnd = 12'($urandom);
      step(1, 0, rnd, 16'd0, 0, 1);
      n_chk++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || interval_cnt_o !== snap) begin
        n_fail++;
        $display("FAIL stall %0d: ready=%b valid=%b cnt=%h required 0, 1, %h", k, ready_o, valid_o, interval_cnt_o, snap);
      end
    end
    push0 = n_push;
    pop0  = n_pop;
    for (int k = 0; k < 8; k++) begin
      rnd = 12'($urandom & $urandom & $urandom);
      step(1, 0, rnd, 16'd0, 1, 1);
    end
    step(0, 0, '0, 16'd0, 1, 1);
    n_chk++;
    if ((n_push - push0) != 8 || (n_pop - pop0) != 9 || sb.size() != 0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_count: pushed=%0d popped=%0d left=%0d valid=%b required 8, 9, 0, 0",
               n_push - push0, n_pop - pop0, sb.size(), valid_o);
    end
  endtask

  task automatic test_restart();
    logic [PARALLEL_SIZE-1:0][PARA-1:0] exp;
    step(1, 0, '0, 16'd0, 1, 1);
    step(1, 0, '0, 16'd0, 1, 1);
    step(1, 1, 12'h0F0, 16'd5, 1, 1);
    for (int i = 0; i < PARALLEL_SIZE; i++) exp[i] = (i >= 4 && i <= 7) ? 16'd0 : 16'd1;
    n_chk++;
    if (interval_cnt_o !== exp || exit_o !== '0 || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: cnt=%h exit=%h valid=%b required cnt=%h exit=0 valid=1", interval_cnt_o, exit_o, valid_o, exp);
    end
    step(1, 1, '0, 16'd1, 1, 1);
    n_chk++;
    if (exit_o !== 12'hFFF || all_exit_o !== 1'b1 || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL patience1: exit=%h all=%b valid=%b required fff, 1, 1", exit_o, all_exit_o, valid_o);
    end
    step(1, 0, '0, 16'd1, 1, 1);
    n_chk++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL patience1_drop: valid=%b required 0", valid_o);
    end
  endtask

  task automatic test_reset_mid_run();
    step(1, 1, '0, 16'd3, 0, 1);
    n_chk++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL held_beat: valid=%b required 1", valid_o);
    end
    step(1, 0, '0, 16'd3, 0, 0);
    n_chk++;
    if (valid_o !== 1'b0 || exit_o !== '0 || all_exit_o !== 1'b0 || interval_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b exit=%h all=%b cnt=%h required all zero", valid_o, exit_o, all_exit_o, interval_cnt_o);
    end
    step(1, 0, '0, 16'd3, 1, 1);
    n_chk++;
    if (valid_o !== 1'b0 || interval_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL idle_drop: valid=%b cnt=%h required 0, 0", valid_o, interval_cnt_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; first_i = 1'b0; ready_i = 1'b1;
    out_of_mode_interval_i = '0; patience_i = '0;
    mcnt = '0; mexit = '0; mstate = IDLE; mvalid = 1'b0;
    @(negedge clk);
    test_reset();
    test_start_and_exit();
    test_lane_reset();
    test_back_pressure();
    test_restart();
    test_reset_mid_run();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
